// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath: opcodes, ALUOp, mux selects
// and the sequencer state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StMemAddr,
    StMemRd,
    StWbMem,
    StMemWr,
    StBranch,
    StJump,
    StTrap
  } state_e;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencer: decodes the opcode, drives datapath enables and selects,
// handshakes with the shared memory, counts retired instructions and traps on bad opcodes.
module mc_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             reg_we_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             busy_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // funct reaches ALU_Control directly; the sequencer only selects ALUOP_FUNCT.
  logic unused_funct;
  assign unused_funct = ^funct_i;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PCSRC_ALU;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALUB_RT;
    alu_op_o     = ALUOP_ADD;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = ALUB_FOUR;
        ir_we_o     = mem_ready_i;
        pc_we_o     = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b_o = ALUB_IMM_SH;
        case (op_i)
          OP_RTYPE:     state_d = StExecR;
          OP_ADDI:      state_d = StExecI;
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          default:      state_d = StTrap;
        endcase
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = StWbR;
      end
      StWbR: begin
        reg_we_o  = 1'b1;
        reg_dst_o = 1'b1;
        retire    = 1'b1;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
        state_d     = StWbI;
      end
      StWbI: begin
        reg_we_o = 1'b1;
        retire   = 1'b1;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
        state_d     = (op_i == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) state_d = StWbMem;
      end
      StWbMem: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
      end
      StMemWr: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        retire    = mem_ready_i;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_we_o     = zero_i;
        retire      = 1'b1;
      end
      StJump: begin
        pc_src_o = PCSRC_JUMP;
        pc_we_o  = 1'b1;
        retire   = 1'b1;
      end
      StTrap: ;
      default: state_d = StIdle;
    endcase

    // Every retiring state hands off the same way, so resolve it once here.
    if (retire) state_d = start_i ? StFetch : StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign busy_o    = (state_q != StIdle) && (state_q != StTrap);
  assign trap_o    = (state_q == StTrap);
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each stimulus cycle queues the expected control
// vector and count; a negedge monitor pops and compares.
module tb_mc_control;

  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, zero_i, mem_ready_i;
  logic [5:0]    op_i, funct_i;
  logic          mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o;
  logic [1:0]    pc_src_o, alu_src_b_o, alu_op_o;
  logic          reg_we_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, busy_o, trap_o;
  logic [CW-1:0] retired_o;

  mc_control #(.CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .funct_i     (funct_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .iord_o      (iord_o),
    .ir_we_o     (ir_we_o),
    .pc_we_o     (pc_we_o),
    .pc_src_o    (pc_src_o),
    .reg_we_o    (reg_we_o),
    .reg_dst_o   (reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .busy_o      (busy_o),
    .trap_o      (trap_o),
    .retired_o   (retired_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  // Field order: mem_req mem_we iord ir_we pc_we pc_src reg_we reg_dst m2r asa asb aop busy trap
  function automatic logic [16:0] mk(input logic mreq, input logic mwe, input logic iord,
                                     input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                     input logic rwe, input logic rdst, input logic m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic busy, input logic trap);
    return {mreq, mwe, iord, irwe, pcwe, pcs, rwe, rdst, m2r, asa, asb, aop, busy, trap};
  endfunction

  logic [16:0] C_IDLE, C_FWAIT, C_FRDY, C_DEC, C_EXR, C_WBR, C_EXI, C_WBI, C_MRD, C_WBM;
  logic [16:0] C_MWR, C_BRZ, C_BRNZ, C_JMP, C_TRAP;

  typedef struct {
    logic [16:0]   ctrl;
    logic [CW-1:0] ret;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [16:0] act_ctrl();
    return {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o, reg_dst_o,
            mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, busy_o, trap_o};
  endfunction

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (act_ctrl() === e.ctrl && retired_o === e.ret) n_pass++;
      else $display("FAIL %s: got ctrl=%b retired=%0d, expected ctrl=%b retired=%0d",
                    e.tag, act_ctrl(), retired_o, e.ctrl, e.ret);
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic [5:0] op, input logic rdy,
                     input logic z, input logic [16:0] ctrl, input int ret, input string tag);
    @(posedge clk_i);
    #1;
    rst_i = rst; start_i = st; op_i = op; mem_ready_i = rdy; zero_i = z;
    q.push_back('{ctrl: ctrl, ret: CW'(ret), tag: tag});
  endtask

  initial begin
    C_IDLE  = '0;
    C_FWAIT = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,2'd0,1,0);
    C_FRDY  = mk(1,0,0,1,1,2'd0,0,0,0,0,2'd1,2'd0,1,0);
    C_DEC   = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd3,2'd0,1,0);
    C_EXR   = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd2,1,0);
    C_WBR   = mk(0,0,0,0,0,2'd0,1,1,0,0,2'd0,2'd0,1,0);
    C_EXI   = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,1,0);
    C_WBI   = mk(0,0,0,0,0,2'd0,1,0,0,0,2'd0,2'd0,1,0);
    C_MRD   = mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,1,0);
    C_WBM   = mk(0,0,0,0,0,2'd0,1,0,1,0,2'd0,2'd0,1,0);
    C_MWR   = mk(1,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,1,0);
    C_BRZ   = mk(0,0,0,0,1,2'd1,0,0,0,1,2'd0,2'd1,1,0);
    C_BRNZ  = mk(0,0,0,0,0,2'd1,0,0,0,1,2'd0,2'd1,1,0);
    C_JMP   = mk(0,0,0,0,1,2'd2,0,0,0,0,2'd0,2'd0,1,0);
    C_TRAP  = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,1);

    rst_i = 0; start_i = 0; op_i = R; funct_i = 6'h20; mem_ready_i = 0; zero_i = 0;
    repeat (2) @(posedge clk_i);
    cyc(1, 0, R, 1, 0, C_IDLE, 0, "reset_idle");

    // R-type, zero-wait memory
    cyc(1, 1, R, 1, 0, C_IDLE,  0, "r_idle");
    cyc(1, 1, R, 1, 0, C_FRDY,  0, "r_fetch");
    cyc(1, 1, R, 1, 0, C_DEC,   0, "r_decode");
    cyc(1, 1, R, 1, 0, C_EXR,   0, "r_exec");
    cyc(1, 0, R, 1, 0, C_WBR,   0, "r_wb");
    cyc(1, 0, R, 1, 0, C_IDLE,  1, "r_done");

    // lw with 2 fetch waits and 3 read waits
    cyc(1, 1, LW, 0, 0, C_IDLE,  1, "lw_idle");
    cyc(1, 1, LW, 0, 0, C_FWAIT, 1, "lw_fwait1");
    cyc(1, 1, LW, 0, 0, C_FWAIT, 1, "lw_fwait2");
    cyc(1, 1, LW, 1, 0, C_FRDY,  1, "lw_fetch");
    cyc(1, 1, LW, 1, 0, C_DEC,   1, "lw_decode");
    cyc(1, 1, LW, 1, 0, C_EXI,   1, "lw_addr");
    cyc(1, 1, LW, 0, 0, C_MRD,   1, "lw_rwait1");
    cyc(1, 1, LW, 0, 0, C_MRD,   1, "lw_rwait2");
    cyc(1, 1, LW, 0, 0, C_MRD,   1, "lw_rwait3");
    cyc(1, 1, LW, 1, 0, C_MRD,   1, "lw_read");
    cyc(1, 0, LW, 1, 0, C_WBM,   1, "lw_wb");
    cyc(1, 0, LW, 1, 0, C_IDLE,  2, "lw_done");

    // beq taken then not taken, back to back
    cyc(1, 1, BEQ, 1, 1, C_IDLE, 2, "beq_idle");
    cyc(1, 1, BEQ, 1, 1, C_FRDY, 2, "beq1_fetch");
    cyc(1, 1, BEQ, 1, 1, C_DEC,  2, "beq1_decode");
    cyc(1, 1, BEQ, 1, 1, C_BRZ,  2, "beq1_taken");
    cyc(1, 1, BEQ, 1, 0, C_FRDY, 3, "beq2_fetch");
    cyc(1, 1, BEQ, 1, 0, C_DEC,  3, "beq2_decode");
    cyc(1, 0, BEQ, 1, 0, C_BRNZ, 3, "beq2_nottaken");
    cyc(1, 0, BEQ, 1, 0, C_IDLE, 4, "beq_done");

    // addi with start dropped in EXEC_I
    cyc(1, 1, ADDI, 1, 0, C_IDLE, 4, "addi_idle");
    cyc(1, 1, ADDI, 1, 0, C_FRDY, 4, "addi_fetch");
    cyc(1, 1, ADDI, 1, 0, C_DEC,  4, "addi_decode");
    cyc(1, 0, ADDI, 1, 0, C_EXI,  4, "addi_exec_stop");
    cyc(1, 0, ADDI, 1, 0, C_WBI,  4, "addi_wb");
    cyc(1, 0, ADDI, 1, 0, C_IDLE, 5, "addi_idle_after");

    // sw with one write wait
    cyc(1, 1, SW, 1, 0, C_IDLE, 5, "sw_idle");
    cyc(1, 1, SW, 1, 0, C_FRDY, 5, "sw_fetch");
    cyc(1, 0, SW, 1, 0, C_DEC,  5, "sw_decode");
    cyc(1, 0, SW, 1, 0, C_EXI,  5, "sw_addr");
    cyc(1, 0, SW, 0, 0, C_MWR,  5, "sw_wwait");
    cyc(1, 0, SW, 1, 0, C_MWR,  5, "sw_write");
    cyc(1, 0, SW, 1, 0, C_IDLE, 6, "sw_done");

    // illegal opcode traps; start ignored; reset clears
    cyc(1, 1, BAD, 1, 1, C_IDLE, 6, "bad_idle");
    cyc(1, 1, BAD, 1, 1, C_FRDY, 6, "bad_fetch");
    cyc(1, 0, BAD, 1, 1, C_DEC,  6, "bad_decode");
    cyc(1, 0, BAD, 1, 1, C_TRAP, 6, "trap_a");
    cyc(1, 1, BAD, 1, 1, C_TRAP, 6, "trap_start_hi");
    cyc(0, 1, BAD, 1, 1, C_TRAP, 6, "trap_rst_cycle");
    cyc(1, 0, R,   1, 0, C_IDLE, 0, "trap_cleared");

    // reset in the middle of a pending fetch drops the request
    cyc(1, 1, J, 0, 0, C_IDLE,  0, "rst_mid_idle");
    cyc(0, 1, J, 0, 0, C_FWAIT, 0, "rst_mid_fetch");
    cyc(1, 0, J, 1, 0, C_IDLE,  0, "rst_mid_dropped");

    // 16 jumps wrap the 4-bit counter
    cyc(1, 1, J, 1, 0, C_IDLE, 0, "wrap_idle");
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, J, 1, 0, C_FRDY, i, "wrap_fetch");
      cyc(1, 1, J, 1, 0, C_DEC,  i, "wrap_decode");
      cyc(1, (i < 15), J, 1, 0, C_JMP, i, "wrap_jump");
    end
    cyc(1, 0, J, 1, 0, C_IDLE, 0, "wrap_done");

    @(posedge clk_i);
    @(posedge clk_i);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
